tm_infer_sequencer: RTL
=======================

// Module: tm_infer_sequencer
// PURPOSE
// Run-level controller for the convolutional TM classifier core. Sequences one inference run:
// clause-BRAM load, weight-BRAM load, then N images. Each image is streamed in as IMG_BEATS
// 128-bit beats, the core's done pulse is awaited, and the class result is queued.
// Sits between the DMA/AXI-Stream source and the classifier core.
// Results go out through a small ready/valid FIFO.
// PARAMETERS
// IMG_BEATS  8     128-bit beats per image (28x28 binarised image, padded)
// RES_DEPTH  4     result FIFO depth; power of two, >=2
// TIMEOUT    4096  max cycles waited for core_done per image before a timeout error
// PORTS
// clk           in   1    clock
// rst_n         in   1    async active-low reset
// start         in   1    1-cycle pulse; starts a run (accepted only in IDLE)
// abort         in   1    synchronous abort, any state
// model_params  in   19   [2:0] patch, [5:3] stride, [14:6] clause count, [18:15] class count
// n_images      in   16   images per run; latched on start
// s_tvalid      in   1    image stream valid
// s_tlast       in   1    image stream last
// s_tready      out  1    image stream ready
// core_tready   in   1    core can accept an image beat
// core_tvalid   out  1    beat valid to core (= s_tvalid in STREAM)
// core_rst      out  1    active-high core reset/hold
// clause_we     out  1    clause BRAM write enable
// clause_addr   out  9    clause BRAM address
// weight_we     out  1    weight BRAM write enable
// weight_addr   out  8    weight BRAM address
// core_done     in   1    1-cycle pulse: core finished current image
// core_class    in   4    class index, valid with core_done
// m_valid       out  1    result valid
// m_ready       in   1    result ready
// m_data        out  16   {img_idx[11:0], class[3:0]}
// busy          out  1    high in every state except IDLE
// run_done      out  1    1-cycle pulse on DONE
// err           out  2    sticky: [0] tlast misplaced, [1] core timeout; cleared on start
// BEHAVIOUR
// - Reset (rst_n=0): state=IDLE. core_rst=1. All other outputs 0. FIFO empty. Counters 0.
// - Encoded states: IDLE, LOAD_CL, LOAD_WT, STREAM, COMPUTE, RESULT, DONE.
// - IDLE: core_rst=1. On start, latch model_params and n_images, clear err, go to LOAD_CL.
// - LOAD_CL: clause_we=1; clause_addr 0..C-1, one address per cycle (C = params[14:6]).
//   When C==0, skip directly to LOAD_WT.
// - LOAD_WT: weight_we=1; weight_addr 0..W-1 with W = classes*5 (8-bit product).
//   When W==0, skip. Exit: n_images==0 -> DONE, else -> STREAM.
// - core_rst=0 in every state from LOAD_CL through RESULT.
// - STREAM: s_tready = core_tready; core_tvalid = s_tvalid. A beat is a cycle with s_tvalid&&core_tready.
//   Beat counter runs 0..IMG_BEATS-1. After the last beat, go to COMPUTE.
//   If s_tlast disagrees with (beat==IMG_BEATS-1), set err[0]. The beat is still consumed; the count is not altered.
// - COMPUTE: s_tready=0. Watchdog counts cycles.
//   On core_done: capture core_class, go to RESULT.
//   When the watchdog reaches TIMEOUT-1: class=4'hF, set err[1], go to RESULT.
// - RESULT: push {img_idx,class} into the FIFO when it is not full; otherwise stall in RESULT.
//   On push, img_idx+1. If img_idx+1==n_images -> DONE, else -> STREAM.
// - DONE: run_done=1 for one cycle, then IDLE. The FIFO keeps draining after the run.
// - FIFO: push and pop in the same cycle are allowed even when full (pop frees the slot first).
//   m_data is stable while m_valid && !m_ready.
// - abort: next state IDLE, FIFO flushed, counters cleared, err kept. abort wins over start and core_done.
// - core_done outside COMPUTE is ignored. start outside IDLE is ignored.
// - img_idx is 12 bits and wraps mod 4096. The run length is set by the 16-bit n_images.
// TESTING
// - C=140, classes=10, n_images=1 -> clause_we high 140 cycles (addr 0..139); weight_we 50 cycles (0..49).
//   Then 8 beats, core_done with class 7 -> m_data=16'h0007, run_done pulses.
// - n_images=3, m_ready=0 throughout, RES_DEPTH=4 -> 3 results queued, no stall, run_done.
//   Then m_ready=1 -> out in order, idx 0,1,2.
// - n_images=6, m_ready=0 -> stalls in RESULT on image 5 (FIFO full), s_tready stays 0.
//   Release m_ready -> completes.
// - Never pulse core_done -> after 4096 cycles m_data class=4'hF, err=2'b10.
// - s_tlast on beat 3 -> err[0]=1, image still takes 8 beats. abort in COMPUTE -> IDLE, m_valid=0, core_rst=1.
// - start with C=0, classes=0, n_images=0 -> no writes; run_done 2-3 cycles after start.

Source files
------------

// File: rtl/tm_infer_sequencer.sv
// tm_infer_sequencer: run-level sequencer for the TM classifier core (BRAM loads, image stream, result FIFO)
// clk, rst_n                 clock, async active-low reset
// start, abort               run start pulse (IDLE only), synchronous abort
// model_params, n_images     run configuration, latched on start
// s_tvalid/s_tlast/s_tready  image stream in; core_tvalid/core_tready beat handoff to core
// core_rst, core_done, core_class  core hold, completion pulse, class index
// clause_we/addr, weight_we/addr   BRAM load strobes
// m_valid/m_ready/m_data     result FIFO out {img_idx[11:0], class[3:0]}
// busy, run_done, err        status; err is sticky {timeout, tlast misplaced}
module tm_infer_sequencer #(
  parameter int IMG_BEATS = 8,
  parameter int RES_DEPTH = 4,
  parameter int TIMEOUT = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic [18:0] model_params,
  input  logic [15:0] n_images,
  input  logic        s_tvalid,
  input  logic        s_tlast,
  output logic        s_tready,
  input  logic        core_tready,
  output logic        core_tvalid,
  output logic        core_rst,
  output logic        clause_we,
  output logic [8:0]  clause_addr,
  output logic        weight_we,
  output logic [7:0]  weight_addr,
  input  logic        core_done,
  input  logic [3:0]  core_class,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [15:0] m_data,
  output logic        busy,
  output logic        run_done,
  output logic [1:0]  err
);
  localparam int AW = $clog2(RES_DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = $clog2(TIMEOUT) > 9 ? $clog2(TIMEOUT) : 9;
  typedef enum logic [2:0] {IDLE, LOAD_CL, LOAD_WT, STREAM, COMPUTE, RESULT, DONE} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n, cnt_inc;
  logic [8:0] n_cl;
  logic [3:0] n_cls, cls, cls_n;
  logic [7:0] n_wt;
  logic [15:0] n_img, img, img_n;
  logic [1:0] err_n;
  logic [PW-1:0] wr, rd;
  logic [15:0] mem [RES_DEPTH];
  logic full, pop, push;
  logic unused_params;
  assign unused_params = ^model_params[5:0];
  assign cnt_inc = cnt + CW'(1);
  assign n_wt = 8'(n_cls) * 8'd5;
  assign full = wr == {~rd[AW], rd[AW-1:0]};
  assign m_valid = wr != rd;
  assign pop = m_valid && m_ready;
  assign m_data = m_valid ? mem[rd[AW-1:0]] : '0;
  assign s_tready = state == STREAM && core_tready;
  assign core_tvalid = state == STREAM && s_tvalid;
  assign core_rst = state == IDLE || state == DONE;
  assign clause_we = state == LOAD_CL && n_cl != '0;
  assign clause_addr = state == LOAD_CL ? cnt[8:0] : '0;
  assign weight_we = state == LOAD_WT && n_wt != '0;
  assign weight_addr = state == LOAD_WT ? cnt[7:0] : '0;
  assign busy = state != IDLE;
  assign run_done = state == DONE;
  // cnt is shared: BRAM address in the load states, beat index in STREAM, watchdog in COMPUTE
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    img_n = img;
    cls_n = cls;
    err_n = err;
    push = 1'b0;
    case (state)
      IDLE: if (start) begin
        state_n = LOAD_CL;
        cnt_n = '0;
        img_n = '0;
        err_n = 2'b00;
      end
      LOAD_CL: if (n_cl == '0 || cnt_inc == CW'(n_cl)) begin
        state_n = LOAD_WT;
        cnt_n = '0;
      end else cnt_n = cnt_inc;
      LOAD_WT: if (n_wt == '0 || cnt_inc == CW'(n_wt)) begin
        state_n = n_img == '0 ? DONE : STREAM;
        cnt_n = '0;
      end else cnt_n = cnt_inc;
      STREAM: if (s_tvalid && core_tready) begin
        err_n[0] = err[0] || (s_tlast != (cnt == CW'(IMG_BEATS - 1)));
        state_n = cnt == CW'(IMG_BEATS - 1) ? COMPUTE : STREAM;
        cnt_n = cnt == CW'(IMG_BEATS - 1) ? '0 : cnt_inc;
      end
      COMPUTE: if (core_done) begin
        cls_n = core_class;
        state_n = RESULT;
      end else if (cnt == CW'(TIMEOUT - 1)) begin
        cls_n = 4'hF;
        err_n[1] = 1'b1;
        state_n = RESULT;
      end else cnt_n = cnt_inc;
      RESULT: begin
        cnt_n = '0;
        if (!full || pop) begin
          push = 1'b1;
          img_n = img + 16'd1;
          state_n = img + 16'd1 == n_img ? DONE : STREAM;
        end
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (abort) begin
      state_n = IDLE;
      cnt_n = '0;
      img_n = '0;
      err_n = err;
      push = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      img <= '0;
      cls <= '0;
      err <= '0;
      n_cl <= '0;
      n_cls <= '0;
      n_img <= '0;
      wr <= '0;
      rd <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      img <= img_n;
      cls <= cls_n;
      err <= err_n;
      if (state == IDLE && start && !abort) begin
        n_cl <= model_params[14:6];
        n_cls <= model_params[18:15];
        n_img <= n_images;
      end
      wr <= abort ? '0 : wr + PW'(push);
      rd <= abort ? '0 : rd + PW'(pop);
    end
  always_ff @(posedge clk)
    if (push) mem[wr[AW-1:0]] <= {img[11:0], cls};
endmodule
